mips_mem_responder: RTL and testbench

//  Single-port 32-bit word-addressed memory responder serving the MIPS32 pipeline.
//  Two requester ports: instruction fetch (read-only) and data (LW/SW).

---
 rtl/mips_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_mips_mem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: single-port word memory shared by the MIPS32 fetch and
// data ports. It arbitrates between the two ports, inserts WAIT_STATES cycles
// between grant and completion, and returns a one-cycle ack for each access.
module mips_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned STARVE_LIM  = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam int unsigned SC_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_port_if;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wait_cnt;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic              w_grant;
  logic              w_grant_if;
  logic [SC_W-1:0]   w_starve_nxt;
  logic              w_enter_resp;
  logic              w_acc_if;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;

  // Next-state, arbitration and starvation-counter update.
  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_if   = 1'b0;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      S_IDLE: begin
        if (if_req || dm_req) begin
          w_grant    = 1'b1;
          w_grant_if = if_req && (!dm_req || (r_starve_cnt == SC_MAX));
          if (w_grant_if) begin
            w_starve_nxt = '0;
          end else if (if_req) begin
            w_starve_nxt = (r_starve_cnt == SC_MAX) ? SC_MAX : r_starve_cnt + 1'b1;
          end else begin
            w_starve_nxt = '0;
          end
          w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Access descriptor seen on the edge entering RESP; with no wait states
  // that edge is the grant edge, so the live request is used directly.
  always_comb begin
    w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    if (r_state == S_IDLE) begin
      w_acc_if   = w_grant_if;
      w_acc_we   = w_grant_if ? 1'b0 : dm_we;
      w_acc_addr = w_grant_if ? if_addr : dm_addr;
    end else begin
      w_acc_if   = r_port_if;
      w_acc_we   = r_we;
      w_acc_addr = r_addr;
    end
  end

  // FSM state register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch, wait counter, starvation counter, acks and read data.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_port_if    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      if (w_grant) begin
        r_port_if  <= w_grant_if;
        r_we       <= w_grant_if ? 1'b0 : dm_we;
        r_addr     <= w_grant_if ? if_addr : dm_addr;
        r_wdata    <= dm_wdata;
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      r_if_ack <= w_enter_resp && w_acc_if;
      r_dm_ack <= w_enter_resp && !w_acc_if;
      if (w_enter_resp && w_acc_if) begin
        r_if_rdata <= r_mem[w_acc_addr];
      end
      if (w_enter_resp && !w_acc_if && !w_acc_we) begin
        r_dm_rdata <= r_mem[w_acc_addr];
      end
    end
  end

  // Store commit on the edge that ends RESP; an asynchronous reset leaves
  // IDLE in place before that edge, so an aborted store never lands.
  always_ff @(posedge clk1) begin
    if ((r_state == S_RESP) && !r_port_if && r_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign if_ack   = r_if_ack;
  assign dm_ack   = r_dm_ack;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;
  assign busy     = (r_state == S_WAIT) || (r_state == S_RESP);

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: instance 0 uses WAIT_STATES=1, instance 1
// uses WAIT_STATES=0. Expected acks are queued when a request is driven and
// checked (cycle, instance, data) when the ack appears.
module tb_mips_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        if_req   [2];
  logic [9:0]  if_addr  [2];
  logic        if_ack   [2];
  logic [31:0] if_rdata [2];
  logic        dm_req   [2];
  logic        dm_we    [2];
  logic [9:0]  dm_addr  [2];
  logic [31:0] dm_wdata [2];
  logic        dm_ack   [2];
  logic [31:0] dm_rdata [2];
  logic        busy     [2];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int          inst;
    logic        we;
    logic [31:0] rdata;
    int unsigned due;
    int          id;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  exp_t        dmq[$];
  exp_t        ifq[$];
  logic [31:0] last_dm [2];
  vec_t        tbl [12];

  mips_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(1), .STARVE_LIM(4)) u_dut0 (
    .clk1(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]), .busy(busy[0])
  );

  mips_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(0), .STARVE_LIM(4)) u_dut1 (
    .clk1(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned ws(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per ack.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      if (!rst_n) last_dm[k] = '0;
      if (if_ack[k] || dm_ack[k]) chk($sformatf("ack_overlap%0d", k), 32'(if_ack[k] && dm_ack[k]), 32'd0);
      if (dm_ack[k]) begin
        if (dmq.size() == 0) begin
          checks++; errors++;
          $display("FAIL dm_ack_unexpected inst%0d: got ack at cycle %0d expected none", k, cyc);
        end else begin
          e = dmq.pop_front();
          chk($sformatf("dm_inst#%0d", e.id), 32'(k), 32'(e.inst));
          chk($sformatf("dm_cycle#%0d", e.id), cyc, e.due);
          if (e.we) begin
            chk($sformatf("dm_rdata_hold#%0d", e.id), dm_rdata[k], last_dm[k]);
          end else begin
            chk($sformatf("dm_rdata#%0d", e.id), dm_rdata[k], e.rdata);
            last_dm[k] = e.rdata;
          end
        end
      end
      if (if_ack[k]) begin
        if (ifq.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_ack_unexpected inst%0d: got ack at cycle %0d expected none", k, cyc);
        end else begin
          e = ifq.pop_front();
          chk($sformatf("if_inst#%0d", e.id), 32'(k), 32'(e.inst));
          chk($sformatf("if_cycle#%0d", e.id), cyc, e.due);
          chk($sformatf("if_rdata#%0d", e.id), if_rdata[k], e.rdata);
        end
      end
    end
  end

  // Waits (bounded) for an ack, then returns 1 time unit after the next edge.
  task automatic wait_ack(int k, logic port);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (port ? if_ack[k] : dm_ack[k]) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ack_timeout inst%0d port%0d: got no ack expected one within 40 cycles", k, port);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic access(int k, logic port, logic we, logic [9:0] a, logic [31:0] d,
                        logic [31:0] exp, int unsigned extra, int id);
    exp_t e;
    e.inst  = k;
    e.we    = port ? 1'b0 : we;
    e.rdata = exp;
    e.due   = cyc + ws(k) + 1 + extra;
    e.id    = id;
    if (port) begin
      ifq.push_back(e);
      if_addr[k] = a;
      if_req[k]  = 1'b1;
      wait_ack(k, 1'b1);
      if_req[k]  = 1'b0;
    end else begin
      dmq.push_back(e);
      dm_addr[k]  = a;
      dm_we[k]    = we;
      dm_wdata[k] = d;
      dm_req[k]   = 1'b1;
      wait_ack(k, 1'b0);
      dm_req[k]   = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    exp_t e;

    tbl[0]  = '{1'b0, 1'b1, 10'd5,    32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 10'd5,    32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 10'd1023, 32'h12345678, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 10'd0,    32'hCAFEF00D, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 10'd0,    32'h0,        32'hCAFEF00D};
    tbl[5]  = '{1'b1, 1'b0, 10'd1023, 32'h0,        32'h12345678};
    tbl[6]  = '{1'b0, 1'b0, 10'd1023, 32'h0,        32'h12345678};
    tbl[7]  = '{1'b0, 1'b1, 10'd1,    32'h0BADF00D, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 10'd1,    32'h0,        32'h0BADF00D};
    tbl[9]  = '{1'b0, 1'b1, 10'd5,    32'h00000000, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 10'd5,    32'h0,        32'h00000000};
    tbl[11] = '{1'b1, 1'b0, 10'd5,    32'h0,        32'h00000000};

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_if_ack%0d", k), 32'(if_ack[k]), 32'd0);
      chk($sformatf("rst_dm_ack%0d", k), 32'(dm_ack[k]), 32'd0);
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst_if_rdata%0d", k), if_rdata[k], 32'd0);
      chk($sformatf("rst_dm_rdata%0d", k), dm_rdata[k], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back single-port accesses, WAIT_STATES=1.
    for (int i = 0; i < 12; i++) begin
      access(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, 0, i);
    end

    // Both requests together: data first, fetch three cycles later.
    fork
      access(0, 1'b0, 1'b0, 10'd1, 32'h0, 32'h0BADF00D, 0, 20);
      access(0, 1'b1, 1'b0, 10'd0, 32'h0, 32'hCAFEF00D, 3, 21);
    join

    // Continuous data requests: four data grants, then fetch wins.
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      e.inst = 0; e.we = 1'b0; e.rdata = 32'h0BADF00D; e.due = c + 2 + 3 * i; e.id = 30 + i;
      dmq.push_back(e);
    end
    e.inst = 0; e.we = 1'b0; e.rdata = 32'hCAFEF00D; e.due = c + 14; e.id = 34;
    ifq.push_back(e);
    dm_addr[0] = 10'd1; dm_we[0] = 1'b0; dm_req[0] = 1'b1;
    if_addr[0] = 10'd0; if_req[0] = 1'b1;
    wait_ack(0, 1'b1);
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    chk("starve_cnt_clear", 32'(u_dut0.r_starve_cnt), 32'd0);

    // Store whose request is dropped and inputs changed during WAIT.
    c = cyc;
    e.inst = 0; e.we = 1'b1; e.rdata = 32'h0; e.due = c + 2; e.id = 40;
    dmq.push_back(e);
    dm_addr[0] = 10'd9; dm_we[0] = 1'b1; dm_wdata[0] = 32'h13579BDF; dm_req[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_in_wait", 32'(busy[0]), 32'd1);
    dm_req[0] = 1'b0; dm_we[0] = 1'b0; dm_addr[0] = 10'd2; dm_wdata[0] = 32'hFFFFFFFF;
    wait_ack(0, 1'b0);
    access(0, 1'b0, 1'b0, 10'd9, 32'h0, 32'h13579BDF, 0, 41);

    // Reset during WAIT of a store aborts it.
    access(0, 1'b0, 1'b1, 10'd7, 32'h00000011, 32'h0, 0, 50);
    dm_addr[0] = 10'd7; dm_we[0] = 1'b1; dm_wdata[0] = 32'h00000022; dm_req[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_before_reset", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("busy_after_reset", 32'(busy[0]), 32'd0);
    chk("dm_ack_after_reset", 32'(dm_ack[0]), 32'd0);
    chk("dm_rdata_after_reset", dm_rdata[0], 32'd0);
    dm_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    access(0, 1'b0, 1'b0, 10'd7, 32'h0, 32'h00000011, 0, 51);

    // WAIT_STATES=0 instance: one-cycle latency, boundary addresses.
    access(1, 1'b0, 1'b1, 10'd0,    32'h5A5A0000, 32'h0,          0, 60);
    access(1, 1'b0, 1'b1, 10'd1023, 32'hA5A5A5A5, 32'h0,          0, 61);
    access(1, 1'b0, 1'b0, 10'd1023, 32'h0,        32'hA5A5A5A5,   0, 62);
    access(1, 1'b0, 1'b0, 10'd0,    32'h0,        32'h5A5A0000,   0, 63);
    access(1, 1'b1, 1'b0, 10'd1023, 32'h0,        32'hA5A5A5A5,   0, 64);

    repeat (4) @(posedge clk);
    #1;
    chk("dmq_empty", 32'(dmq.size()), 32'd0);
    chk("ifq_empty", 32'(ifq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
